// File: rtl/muldiv_cycle_sequencer_pkg.sv
// Shared definitions for the mul/div cycle sequencer.
// Default iteration counts and the 2-bit FSM state encoding.
package muldiv_cycle_sequencer_pkg;

    localparam int DEF_WIDTH       = 6;
    localparam int DEF_MULT_CYCLES = 16;
    localparam int DEF_DIV_CYCLES  = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic int max_cycles(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/muldiv_cycle_sequencer_cycle_count_reg.sv
// Iteration counter: async active-low reset, sync clear,
// load of a terminal value, and increment enable (clr > load > inc).
module cycle_count_reg #(
    parameter int WIDTH = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/muldiv_cycle_sequencer.sv
// Start/busy/ready sequencer for the multi-cycle mul/div datapath.
// Issues step/last strobes per iteration and a one-cycle result_rdy.
module muldiv_cycle_sequencer
    import muldiv_cycle_sequencer_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             is_div,
    output logic             step,
    output logic             last,
    output logic             result_rdy,
    output logic             start_err
);

    if ((1 << WIDTH) <= max_cycles(MULT_CYCLES, DIV_CYCLES)) begin : g_bad_width
        $error("WIDTH too small to hold the iteration count");
    end
    if (MULT_CYCLES < 1 || DIV_CYCLES < 1) begin : g_bad_cycles
        $error("MULT_CYCLES and DIV_CYCLES must be >= 1");
    end

    localparam logic [WIDTH-1:0] N_MULT    = WIDTH'(MULT_CYCLES);
    localparam logic [WIDTH-1:0] N_DIV     = WIDTH'(DIV_CYCLES);
    localparam logic [WIDTH-1:0] N_MULT_M1 = WIDTH'(MULT_CYCLES - 1);
    localparam logic [WIDTH-1:0] N_DIV_M1  = WIDTH'(DIV_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic             is_last;
    logic             req_ok;
    logic             req_bad;
    logic             any_start;
    logic [WIDTH-1:0] n_val;

    assign any_start = start_mult | start_div;
    assign n_val     = is_div ? N_DIV : N_MULT;
    assign is_last   = (state == ST_RUN) &&
                       (count == (is_div ? N_DIV_M1 : N_MULT_M1));

    // Only IDLE/DONE accept; RUN treats any start as a protocol error.
    assign req_ok  = !abort && (state != ST_RUN) && (start_mult ^ start_div);
    assign req_bad = !abort &&
                     (((state != ST_RUN) && start_mult && start_div) ||
                      ((state == ST_RUN) && any_start));

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: if (req_ok) state_nxt = ST_RUN;
                ST_RUN:  if (is_last) state_nxt = ST_DONE;
                ST_DONE: state_nxt = req_ok ? ST_RUN : ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            is_div     <= 1'b0;
            busy       <= 1'b0;
            result_rdy <= 1'b0;
            start_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            busy       <= (state_nxt == ST_RUN);
            result_rdy <= (state_nxt == ST_DONE);
            start_err  <= req_bad;
            if (req_ok) begin
                is_div <= start_div;
            end
        end
    end

    cycle_count_reg #(
        .WIDTH(WIDTH)
    ) u_count (
        .clock   (clock),
        .reset   (reset),
        .clr     (abort || (state != ST_RUN)),
        .inc     (!abort && (state == ST_RUN) && !is_last),
        .load    (!abort && is_last),
        .load_val(n_val),
        .count   (count)
    );

    assign step = busy;
    assign last = is_last;

endmodule
